// File: rtl/gcd_issue.sv
// gcd_issue: front-end sequencer for a GCD controller/datapath pair.
// It accepts an operand pair and resolves zero operands locally.
// Otherwise it resets the core, drives A then B on the shared operand bus,
// waits for done under a watchdog, and returns the result (or a timeout
// error) over an output valid/ready handshake.
module gcd_issue #(
  parameter int WIDTH      = 8,
  parameter int TIMEOUT    = 1023,
  parameter int CLR_CYCLES = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic             out_err,
  output logic             core_rst_n,
  output logic             core_start,
  output logic [WIDTH-1:0] core_data,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_result
);

  localparam int WD_W   = $clog2(TIMEOUT + 1);
  // The phase counter covers both the CLEAR hold and the 2-cycle issue slots.
  localparam int PH_MAX = (CLR_CYCLES > 2) ? CLR_CYCLES : 2;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  localparam logic [PH_W-1:0] CLR_LAST   = PH_W'(CLR_CYCLES - 1);
  localparam logic [PH_W-1:0] ISSUE_LAST = PH_W'(1);
  localparam logic [WD_W-1:0] WD_LAST    = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ISSUE_A,
    S_ISSUE_B,
    S_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic              res_load;
  logic [WIDTH-1:0]  res_gcd;
  logic              res_err;
  logic              accept;

  // At most one operation in flight: new pairs wait until the result drains.
  assign in_ready = (state_q == S_IDLE) && !out_valid;
  assign accept   = in_valid && in_ready;

  // The core stays in reset while the block is in reset and during CLEAR.
  assign core_rst_n = reset_n && (state_q != S_CLEAR);

  // Next-state, counter and result-load decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    phase_d    = phase_q;
    wd_d       = wd_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    res_load   = 1'b0;
    res_gcd    = '0;
    res_err    = 1'b0;
    core_start = 1'b0;
    core_data  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_a_d = in_a;
          op_b_d = in_b;
          if ((in_a == '0) || (in_b == '0)) begin
            // gcd(x, 0) = x, and gcd(0, 0) is reported as 0.
            res_load = 1'b1;
            res_gcd  = in_a | in_b;
          end else begin
            state_d = S_CLEAR;
            phase_d = '0;
          end
        end
      end

      S_CLEAR: begin
        if (phase_q == CLR_LAST) begin
          state_d = S_ISSUE_A;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_ISSUE_A: begin
        core_data  = op_a_q;
        core_start = (phase_q == '0);
        if (phase_q == ISSUE_LAST) begin
          state_d = S_ISSUE_B;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_ISSUE_B: begin
        core_data = op_b_q;
        if (phase_q == ISSUE_LAST) begin
          state_d = S_WAIT;
          phase_d = '0;
          wd_d    = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      S_WAIT: begin
        core_data = op_b_q;
        // done takes priority over a watchdog expiry in the same cycle.
        if (core_done) begin
          res_load = 1'b1;
          res_gcd  = core_result;
          state_d  = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          res_load = 1'b1;
          res_err  = 1'b1;
          state_d  = S_IDLE;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and operand registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      wd_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      phase_q <= phase_d;
      wd_q    <= wd_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
    end
  end

  // Result register: hold until the consumer takes it; reset drops it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_gcd   <= '0;
      out_err   <= 1'b0;
    end else if (res_load) begin
      out_valid <= 1'b1;
      out_gcd   <= res_gcd;
      out_err   <= res_err;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_issue.sv
// tb_gcd_issue: directed bench for gcd_issue with a scripted core
// (the bench drives core_done/core_result with hand-computed GCDs).
module tb_gcd_issue;

  localparam int WIDTH      = 8;
  localparam int TIMEOUT    = 16;
  localparam int CLR_CYCLES = 2;

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_gcd;
  logic             out_err;
  logic             core_rst_n;
  logic             core_start;
  logic [WIDTH-1:0] core_data;
  logic             core_done;
  logic [WIDTH-1:0] core_result;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  gcd_issue #(
    .WIDTH      (WIDTH),
    .TIMEOUT    (TIMEOUT),
    .CLR_CYCLES (CLR_CYCLES)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_gcd     (out_gcd),
    .out_err     (out_err),
    .core_rst_n  (core_rst_n),
    .core_start  (core_start),
    .core_data   (core_data),
    .core_done   (core_done),
    .core_result (core_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Advance one cycle; sample and drive 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a pair for one edge; afterwards the bench sits in cycle k+1.
  task automatic accept_pair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
    in_valid = 1'b0;
  endtask

  // From the first CLEAR cycle to the first WAIT cycle.
  task automatic to_wait();
    repeat (CLR_CYCLES + 4) step();
  endtask

  // Scripted core: after 'delay' WAIT cycles report done with 'res'.
  task automatic finish_core(input logic [WIDTH-1:0] res, input int delay);
    repeat (delay) step();
    core_result = res;
    core_done   = 1'b1;
    step();
    core_done   = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0d expected 0", out_valid); else pass_cnt++;
    total_cnt++; if (out_gcd !== 8'd0) $display("FAIL rst_out_gcd: got %0d expected 0", out_gcd); else pass_cnt++;
    total_cnt++; if (out_err !== 1'b0) $display("FAIL rst_out_err: got %0d expected 0", out_err); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b0) $display("FAIL rst_core_rst_n: got %0d expected 0", core_rst_n); else pass_cnt++;
    total_cnt++; if (core_start !== 1'b0 || core_data !== 8'd0) $display("FAIL rst_core_bus: got start=%0d data=%0d expected 0/0", core_start, core_data); else pass_cnt++;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0d expected 1", in_ready); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b1) $display("FAIL rst_release_core_rst_n: got %0d expected 1", core_rst_n); else pass_cnt++;
  endtask

  task automatic test_basic();
    int k_cyc;
    logic early;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL basic_in_ready: got %0d expected 1", in_ready); else pass_cnt++;
    accept_pair(8'd12, 8'd18);
    k_cyc = cyc;
    for (int i = 0; i < CLR_CYCLES; i++) begin
      total_cnt++; if (core_rst_n !== 1'b0 || core_start !== 1'b0) $display("FAIL basic_clear%0d: got rst_n=%0d start=%0d expected 0/0", i, core_rst_n, core_start); else pass_cnt++;
      step();
    end
    total_cnt++; if (core_start !== 1'b1 || core_data !== 8'd12 || core_rst_n !== 1'b1) $display("FAIL basic_issue_a0: got start=%0d data=%0d rst_n=%0d expected 1/12/1", core_start, core_data, core_rst_n); else pass_cnt++;
    step();
    total_cnt++; if (core_start !== 1'b0 || core_data !== 8'd12) $display("FAIL basic_issue_a1: got start=%0d data=%0d expected 0/12", core_start, core_data); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++; if (core_start !== 1'b0 || core_data !== 8'd18) $display("FAIL basic_issue_b%0d: got start=%0d data=%0d expected 0/18", i, core_start, core_data); else pass_cnt++;
    end
    step();
    early = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (out_valid !== 1'b0 || core_data !== 8'd18) early = 1'b1;
      step();
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL basic_wait: got early=%0d expected 0", early); else pass_cnt++;
    core_result = 8'd6;
    core_done   = 1'b1;
    step();
    core_done = 1'b0;
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd6 || out_err !== 1'b0) $display("FAIL basic_result: got v=%0d gcd=%0d err=%0d expected 1/6/0", out_valid, out_gcd, out_err); else pass_cnt++;
    // Accept cycle k+1, WAIT at k+CLR+5, done in third WAIT cycle, result one later.
    total_cnt++; if (cyc - k_cyc !== CLR_CYCLES + 7) $display("FAIL basic_latency: got %0d expected %0d", cyc - k_cyc, CLR_CYCLES + 7); else pass_cnt++;
    drain();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL basic_drain: got v=%0d rdy=%0d expected 0/1", out_valid, in_ready); else pass_cnt++;
  endtask

  task automatic test_bypass();
    accept_pair(8'd0, 8'd9);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd9 || out_err !== 1'b0) $display("FAIL bypass_0_9: got v=%0d gcd=%0d err=%0d expected 1/9/0", out_valid, out_gcd, out_err); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b1 || core_start !== 1'b0 || core_data !== 8'd0) $display("FAIL bypass_core: got rst_n=%0d start=%0d data=%0d expected 1/0/0", core_rst_n, core_start, core_data); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bypass_in_ready: got %0d expected 0", in_ready); else pass_cnt++;
    drain();
    accept_pair(8'd0, 8'd0);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd0 || out_err !== 1'b0) $display("FAIL bypass_0_0: got v=%0d gcd=%0d err=%0d expected 1/0/0", out_valid, out_gcd, out_err); else pass_cnt++;
    drain();
  endtask

  task automatic test_timeout();
    logic early;
    accept_pair(8'd7, 8'd5);
    to_wait();
    early = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      if (out_valid !== 1'b0 || core_data !== 8'd5) early = 1'b1;
      step();
    end
    total_cnt++; if (early !== 1'b0) $display("FAIL timeout_early: got %0d expected 0", early); else pass_cnt++;
    total_cnt++; if (out_valid !== 1'b1 || out_err !== 1'b1 || out_gcd !== 8'd0) $display("FAIL timeout_result: got v=%0d err=%0d gcd=%0d expected 1/1/0", out_valid, out_err, out_gcd); else pass_cnt++;
    drain();
    accept_pair(8'd8, 8'd12);
    to_wait();
    finish_core(8'd4, 0);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd4 || out_err !== 1'b0) $display("FAIL timeout_recover: got v=%0d gcd=%0d err=%0d expected 1/4/0", out_valid, out_gcd, out_err); else pass_cnt++;
    drain();
  endtask

  task automatic test_backpressure();
    logic bad;
    accept_pair(8'd21, 8'd14);
    to_wait();
    finish_core(8'd7, 3);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_a      = 8'd3;
    in_b      = 8'd6;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_gcd !== 8'd7 || out_err !== 1'b0 || in_ready !== 1'b0 || core_rst_n !== 1'b1) bad = 1'b1;
      step();
    end
    total_cnt++; if (bad !== 1'b0) $display("FAIL bp_hold: got bad=%0d expected 0", bad); else pass_cnt++;
    out_ready = 1'b1;
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd7 || in_ready !== 1'b0) $display("FAIL bp_pre_handshake: got v=%0d gcd=%0d rdy=%0d expected 1/7/0", out_valid, out_gcd, in_ready); else pass_cnt++;
    step();
    out_ready = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_rst_n !== 1'b1) $display("FAIL bp_released: got v=%0d rdy=%0d rst_n=%0d expected 0/1/1", out_valid, in_ready, core_rst_n); else pass_cnt++;
    step();
    in_valid = 1'b0;
    total_cnt++; if (core_rst_n !== 1'b0 || in_ready !== 1'b0) $display("FAIL bp_next_accept: got rst_n=%0d rdy=%0d expected 0/0", core_rst_n, in_ready); else pass_cnt++;
    to_wait();
    finish_core(8'd3, 0);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd3) $display("FAIL bp_next_result: got v=%0d gcd=%0d expected 1/3", out_valid, out_gcd); else pass_cnt++;
    drain();
  endtask

  task automatic test_spurious_done();
    core_result = 8'd77;
    core_done   = 1'b1;
    step();
    core_done = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || core_rst_n !== 1'b1) $display("FAIL spur_idle: got v=%0d rdy=%0d rst_n=%0d expected 0/1/1", out_valid, in_ready, core_rst_n); else pass_cnt++;
    accept_pair(8'd9, 8'd6);
    core_result = 8'd99;
    core_done   = 1'b1;
    step();
    core_done = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || core_rst_n !== 1'b0) $display("FAIL spur_clear: got v=%0d rst_n=%0d expected 0/0", out_valid, core_rst_n); else pass_cnt++;
    step();
    total_cnt++; if (core_start !== 1'b1 || core_data !== 8'd9) $display("FAIL spur_issue_a0: got start=%0d data=%0d expected 1/9", core_start, core_data); else pass_cnt++;
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    total_cnt++; if (out_valid !== 1'b0 || core_data !== 8'd9 || core_start !== 1'b0) $display("FAIL spur_issue_a1: got v=%0d data=%0d start=%0d expected 0/9/0", out_valid, core_data, core_start); else pass_cnt++;
    repeat (3) step();
    finish_core(8'd3, 1);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd3 || out_err !== 1'b0) $display("FAIL spur_result: got v=%0d gcd=%0d err=%0d expected 1/3/0", out_valid, out_gcd, out_err); else pass_cnt++;
    drain();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    accept_pair(8'd0, 8'd5);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd5 || in_ready !== 1'b0) $display("FAIL b2b_bypass: got v=%0d gcd=%0d rdy=%0d expected 1/5/0", out_valid, out_gcd, in_ready); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_bypass_next: got v=%0d rdy=%0d expected 0/1", out_valid, in_ready); else pass_cnt++;
    accept_pair(8'd6, 8'd4);
    to_wait();
    finish_core(8'd2, 0);
    total_cnt++; if (out_valid !== 1'b1 || out_gcd !== 8'd2) $display("FAIL b2b_core: got v=%0d gcd=%0d expected 1/2", out_valid, out_gcd); else pass_cnt++;
    step();
    total_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL b2b_core_next: got v=%0d rdy=%0d expected 0/1", out_valid, in_ready); else pass_cnt++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic stale;
    accept_pair(8'd10, 8'd4);
    to_wait();
    repeat (2) step();
    #2;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (out_valid !== 1'b0 || out_gcd !== 8'd0 || out_err !== 1'b0) $display("FAIL midrst_result: got v=%0d gcd=%0d err=%0d expected 0/0/0", out_valid, out_gcd, out_err); else pass_cnt++;
    total_cnt++; if (core_rst_n !== 1'b0 || core_start !== 1'b0 || core_data !== 8'd0) $display("FAIL midrst_core: got rst_n=%0d start=%0d data=%0d expected 0/0/0", core_rst_n, core_start, core_data); else pass_cnt++;
    step();
    reset_n = 1'b1;
    step();
    total_cnt++; if (in_ready !== 1'b1 || core_rst_n !== 1'b1) $display("FAIL midrst_release: got rdy=%0d rst_n=%0d expected 1/1", in_ready, core_rst_n); else pass_cnt++;
    stale = 1'b0;
    for (int i = 0; i < TIMEOUT + 4; i++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      step();
    end
    total_cnt++; if (stale !== 1'b0) $display("FAIL midrst_stale: got %0d expected 0", stale); else pass_cnt++;
  endtask

  initial begin
    reset_n     = 1'b0;
    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    out_ready   = 1'b0;
    core_done   = 1'b0;
    core_result = '0;
    test_reset();
    test_basic();
    test_bypass();
    test_timeout();
    test_backpressure();
    test_spurious_done();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  // Hard bound on simulated time in case the sequence ever stalls.
  initial begin
    #50000;
    $display("FAIL sim_time_limit: got no finish expected finish before 50000");
    $fatal(1);
  end

endmodule
